// File: rtl/mnist_pkg.sv
// Shared constants and sequencer state encoding for the MNIST inference datapath.
package mnist_pkg;

    localparam int N_IN  = 784;
    localparam int N_HID = 32;
    localparam int N_OUT = 10;
    localparam int CTR_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_L1       = 3'd1,
        ST_L1_DRAIN = 3'd2,
        ST_ACT      = 3'd3,
        ST_L2       = 3'd4,
        ST_L2_DRAIN = 3'd5,
        ST_DONE     = 3'd6
    } seq_state_t;

endpackage

// File: rtl/layer_addr_ctr.sv
// Per-layer address walker: issues addresses 0..LAST, clears the accumulator on
// entry and re-times valid/idx/bias by one cycle to line up with the memory's
// registered read port.
module layer_addr_ctr #(
    parameter int               CTR_W = 32,
    parameter logic [CTR_W-1:0] LAST  = {CTR_W{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enter,
    input  logic             active,
    input  logic             hold,
    output logic             last_issue,
    output logic [CTR_W-1:0] ctr,
    output logic             acc_clr,
    output logic             valid,
    output logic [CTR_W-1:0] idx,
    output logic             bias
);

    logic issue;
    logic at_last;

    // Issue qualification and last-address detect from the registered counter.
    always_comb begin
        issue      = active & ~hold;
        at_last    = (ctr == LAST);
        last_issue = issue & at_last;
    end

    // Counter, entry clear and one-cycle read-latency alignment registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctr     <= {CTR_W{1'b0}};
            acc_clr <= 1'b0;
            valid   <= 1'b0;
            idx     <= {CTR_W{1'b0}};
            bias    <= 1'b0;
        end else if (clear) begin
            ctr     <= {CTR_W{1'b0}};
            acc_clr <= 1'b0;
            valid   <= 1'b0;
            idx     <= {CTR_W{1'b0}};
            bias    <= 1'b0;
        end else begin
            acc_clr <= enter;
            valid   <= issue;
            bias    <= issue & at_last;
            if (enter) begin
                ctr <= {CTR_W{1'b0}};
            end else if (issue && (ctr < LAST)) begin
                // Saturates at LAST: the bias address is issued once, never wrapped past.
                ctr <= ctr + {{(CTR_W-1){1'b0}}, 1'b1};
            end else begin
                ctr <= ctr;
            end
            // idx only moves with a fresh word so it stays stable while valid is low.
            if (issue) begin
                idx <= ctr;
            end else begin
                idx <= idx;
            end
        end
    end

endmodule

// File: rtl/mnist_seq_ctrl.sv
// Two-layer MNIST inference sequencer: walks layer-1 weights, fires the hidden
// activation, walks layer-2 weights and signals completion.
module mnist_seq_ctrl #(
    parameter int N_IN  = mnist_pkg::N_IN,
    parameter int N_HID = mnist_pkg::N_HID,
    parameter int CTR_W = mnist_pkg::CTR_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    output logic             busy,
    output logic [CTR_W-1:0] ctr1,
    output logic [CTR_W-1:0] ctr2,
    output logic             acc_clr1,
    output logic             acc_clr2,
    output logic             l1_valid,
    output logic             l2_valid,
    output logic [CTR_W-1:0] l1_idx,
    output logic [CTR_W-1:0] l2_idx,
    output logic             l1_bias,
    output logic             l2_bias,
    output logic             relu_en,
    output logic             done
);

    import mnist_pkg::*;

    seq_state_t state;
    logic       enter1;
    logic       enter2;
    logic       active1;
    logic       active2;
    logic       last1;
    logic       last2;

    // Layer entry and activity decode from the current state.
    always_comb begin
        enter1  = (state == ST_IDLE) & start & ~abort;
        enter2  = (state == ST_ACT) & ~abort;
        active1 = (state == ST_L1);
        active2 = (state == ST_L2);
    end

    layer_addr_ctr #(
        .CTR_W (CTR_W),
        .LAST  (CTR_W'(N_IN))
    ) u_l1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (abort),
        .enter      (enter1),
        .active     (active1),
        .hold       (hold),
        .last_issue (last1),
        .ctr        (ctr1),
        .acc_clr    (acc_clr1),
        .valid      (l1_valid),
        .idx        (l1_idx),
        .bias       (l1_bias)
    );

    layer_addr_ctr #(
        .CTR_W (CTR_W),
        .LAST  (CTR_W'(N_HID))
    ) u_l2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (abort),
        .enter      (enter2),
        .active     (active2),
        .hold       (hold),
        .last_issue (last2),
        .ctr        (ctr2),
        .acc_clr    (acc_clr2),
        .valid      (l2_valid),
        .idx        (l2_idx),
        .bias       (l2_bias)
    );

    // Sequencer FSM with registered busy, relu_en and done strobes; abort wins over everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            relu_en <= 1'b0;
            done    <= 1'b0;
        end else if (abort) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            relu_en <= 1'b0;
            done    <= 1'b0;
        end else begin
            relu_en <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_L1;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_L1: begin
                    if (last1) begin
                        state <= ST_L1_DRAIN;
                    end else begin
                        state <= ST_L1;
                    end
                end
                ST_L1_DRAIN: begin
                    // The bias word lands this cycle; activation follows once it is accumulated.
                    state   <= ST_ACT;
                    relu_en <= 1'b1;
                end
                ST_ACT: begin
                    state <= ST_L2;
                end
                ST_L2: begin
                    if (last2) begin
                        state <= ST_L2_DRAIN;
                    end else begin
                        state <= ST_L2;
                    end
                end
                ST_L2_DRAIN: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mnist_seq_ctrl.sv
// Self-checking bench for mnist_seq_ctrl: scoreboard of expected idx beats per
// layer plus cycle-accurate checks of the control strobes.
module tb_mnist_seq_ctrl;

    localparam int N_IN  = 784;
    localparam int N_HID = 32;
    localparam int CTR_W = 32;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b1;
    logic             start   = 1'b0;
    logic             abort   = 1'b0;
    logic             hold    = 1'b0;
    logic             busy;
    logic [CTR_W-1:0] ctr1;
    logic [CTR_W-1:0] ctr2;
    logic             acc_clr1;
    logic             acc_clr2;
    logic             l1_valid;
    logic             l2_valid;
    logic [CTR_W-1:0] l1_idx;
    logic [CTR_W-1:0] l2_idx;
    logic             l1_bias;
    logic             l2_bias;
    logic             relu_en;
    logic             done;

    mnist_seq_ctrl #(
        .N_IN  (N_IN),
        .N_HID (N_HID),
        .CTR_W (CTR_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .hold     (hold),
        .busy     (busy),
        .ctr1     (ctr1),
        .ctr2     (ctr2),
        .acc_clr1 (acc_clr1),
        .acc_clr2 (acc_clr2),
        .l1_valid (l1_valid),
        .l2_valid (l2_valid),
        .l1_idx   (l1_idx),
        .l2_idx   (l2_idx),
        .l1_bias  (l1_bias),
        .l2_bias  (l2_bias),
        .relu_en  (relu_en),
        .done     (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cnum  = 0;
    int base  = 0;
    int done_cnt = 0;
    int relu_cnt = 0;
    int clr1_cnt = 0;
    int clr2_cnt = 0;
    int done_c = -1;
    int relu_c = -1;
    int clr1_c = -1;
    int clr2_c = -1;
    int l1_beats = 0;
    int l2_beats = 0;
    int q1[$];
    int q2[$];

    function automatic bit outs_zero();
        return ({busy, acc_clr1, acc_clr2, l1_valid, l2_valid, l1_bias, l2_bias, relu_en, done} === 9'b0)
            && (ctr1 === 32'd0) && (ctr2 === 32'd0) && (l1_idx === 32'd0) && (l2_idx === 32'd0);
    endfunction

    // One clock: sample 1 time unit after the edge, pop the scoreboard, log strobes.
    task automatic step();
        int e;
        @(posedge clk);
        #1;
        cnum++;
        if (l1_valid === 1'b1) begin
            l1_beats++;
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL l1_extra_beat: idx=%0d, no beat expected (cycle %0d)", l1_idx, cnum - base);
            end else begin
                e = q1.pop_front();
                if (l1_idx !== CTR_W'(e) || l1_bias !== (e == N_IN)) begin
                    fails++;
                    $display("FAIL l1_beat: idx=%0d bias=%b, expected idx=%0d bias=%b (cycle %0d)",
                             l1_idx, l1_bias, e, (e == N_IN), cnum - base);
                end
            end
        end
        if (l2_valid === 1'b1) begin
            l2_beats++;
            tests++;
            if (q2.size() == 0) begin
                fails++;
                $display("FAIL l2_extra_beat: idx=%0d, no beat expected (cycle %0d)", l2_idx, cnum - base);
            end else begin
                e = q2.pop_front();
                if (l2_idx !== CTR_W'(e) || l2_bias !== (e == N_HID)) begin
                    fails++;
                    $display("FAIL l2_beat: idx=%0d bias=%b, expected idx=%0d bias=%b (cycle %0d)",
                             l2_idx, l2_bias, e, (e == N_HID), cnum - base);
                end
            end
        end
        if (done === 1'b1)     begin done_cnt++; done_c = cnum; end
        if (relu_en === 1'b1)  begin relu_cnt++; relu_c = cnum; end
        if (acc_clr1 === 1'b1) begin clr1_cnt++; clr1_c = cnum; end
        if (acc_clr2 === 1'b1) begin clr2_cnt++; clr2_c = cnum; end
    endtask

    // Queue the expected beats of one full run and pulse start; base marks c0.
    task automatic launch();
        for (int i = 0; i <= N_IN; i++) q1.push_back(i);
        for (int i = 0; i <= N_HID; i++) q2.push_back(i);
        start = 1'b1;
        step();
        start = 1'b0;
        base = cnum;
    endtask

    task automatic run_to_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) step();
        tests++;
        if (done_cnt == d0) begin
            fails++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        #3;
        reset_n = 1'b0;
        #1;
        tests++;
        if (!outs_zero()) begin
            fails++;
            $display("FAIL reset_state: busy=%b ctr1=%0d ctr2=%0d, expected all zero", busy, ctr1, ctr2);
        end
        step();
        step();
        reset_n = 1'b1;
        step();
        tests++;
        if (!outs_zero()) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b ctr1=%0d, expected all zero", busy, ctr1);
        end
    endtask

    task automatic test_nominal();
        int b1, b2, r0, c20;
        b1 = l1_beats; b2 = l2_beats; r0 = relu_cnt; c20 = clr2_cnt;
        launch();
        tests++;
        if (acc_clr1 !== 1'b1 || ctr1 !== 32'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL c0_state: acc_clr1=%b ctr1=%0d busy=%b, expected 1 0 1", acc_clr1, ctr1, busy);
        end
        step();
        tests++;
        if (acc_clr1 !== 1'b0) begin
            fails++;
            $display("FAIL clr1_width: acc_clr1=%b at c1, expected 0", acc_clr1);
        end
        run_to_done(2000);
        tests++;
        if (done_c - base != 821) begin
            fails++;
            $display("FAIL done_cycle: c%0d, expected c821", done_c - base);
        end
        tests++;
        if (relu_c - base != 786 || relu_cnt != r0 + 1) begin
            fails++;
            $display("FAIL relu_cycle: c%0d count %0d, expected c786 count 1", relu_c - base, relu_cnt - r0);
        end
        tests++;
        if (clr2_c - base != 787 || clr2_cnt != c20 + 1) begin
            fails++;
            $display("FAIL clr2_cycle: c%0d count %0d, expected c787 count 1", clr2_c - base, clr2_cnt - c20);
        end
        tests++;
        if (l1_beats - b1 != N_IN + 1 || l2_beats - b2 != N_HID + 1) begin
            fails++;
            $display("FAIL beat_count: l1=%0d l2=%0d, expected 785 33", l1_beats - b1, l2_beats - b2);
        end
        step();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL c822_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
        tests++;
        if (q1.size() != 0 || q2.size() != 0) begin
            fails++;
            $display("FAIL nominal_missing: %0d l1 and %0d l2 beats never arrived", q1.size(), q2.size());
        end
    endtask

    task automatic test_hold();
        int b1;
        launch();
        while (cnum - base < 100) step();
        tests++;
        if (ctr1 !== 32'd100) begin
            fails++;
            $display("FAIL hold_setup: ctr1=%0d at c100, expected 100", ctr1);
        end
        hold = 1'b1;
        b1 = l1_beats;
        repeat (5) step();
        hold = 1'b0;
        tests++;
        if (ctr1 !== 32'd100 || l1_beats != b1) begin
            fails++;
            $display("FAIL hold_freeze: ctr1=%0d beats=%0d, expected 100 and 0 beats", ctr1, l1_beats - b1);
        end
        run_to_done(2000);
        tests++;
        if (done_c - base != 826) begin
            fails++;
            $display("FAIL hold_done_cycle: c%0d, expected c826", done_c - base);
        end
        tests++;
        if (q1.size() != 0 || q2.size() != 0) begin
            fails++;
            $display("FAIL hold_missing: %0d l1 and %0d l2 beats never arrived", q1.size(), q2.size());
        end
        repeat (2) step();
    endtask

    task automatic test_start_during_run();
        int d0;
        d0 = done_cnt;
        launch();
        while (cnum - base < 400) step();
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_during_start: busy=%b, expected 1", busy);
        end
        run_to_done(2000);
        tests++;
        if (done_c - base != 821) begin
            fails++;
            $display("FAIL restart_ignored_done: c%0d, expected c821", done_c - base);
        end
        repeat (10) step();
        tests++;
        if (done_cnt != d0 + 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_done: done count %0d busy=%b, expected 1 and 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_abort();
        int d0, r0;
        launch();
        while (cnum - base < 790) step();
        d0 = done_cnt; r0 = relu_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++;
        if (!outs_zero()) begin
            fails++;
            $display("FAIL abort_clear: busy=%b ctr1=%0d ctr2=%0d l2_valid=%b, expected all zero",
                     busy, ctr1, ctr2, l2_valid);
        end
        tests++;
        if (q2.size() != N_HID + 1 - 3) begin
            fails++;
            $display("FAIL abort_beats: %0d l2 beats left, expected %0d", q2.size(), N_HID + 1 - 3);
        end
        q1.delete();
        q2.delete();
        repeat (40) step();
        tests++;
        if (done_cnt != d0 || relu_cnt != r0) begin
            fails++;
            $display("FAIL abort_no_done: done %0d relu %0d extra pulses, expected 0 0", done_cnt - d0, relu_cnt - r0);
        end
        launch();
        run_to_done(2000);
        tests++;
        if (done_c - base != 821) begin
            fails++;
            $display("FAIL post_abort_done: c%0d, expected c821", done_c - base);
        end
        repeat (2) step();
    endtask

    task automatic test_reset_mid_run();
        launch();
        while (cnum - base < 300) step();
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (!outs_zero()) begin
            fails++;
            $display("FAIL async_reset: busy=%b ctr1=%0d l1_valid=%b, expected all zero", busy, ctr1, l1_valid);
        end
        q1.delete();
        q2.delete();
        step();
        step();
        reset_n = 1'b1;
        step();
        launch();
        run_to_done(2000);
        tests++;
        if (done_c - base != 821) begin
            fails++;
            $display("FAIL post_reset_done: c%0d, expected c821", done_c - base);
        end
        repeat (2) step();
    endtask

    task automatic test_back_to_back();
        launch();
        run_to_done(2000);
        tests++;
        if (done_c - base != 821) begin
            fails++;
            $display("FAIL b2b_first_done: c%0d, expected c821", done_c - base);
        end
        step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: busy=%b at c822, expected 0", busy);
        end
        launch();
        tests++;
        if (acc_clr1 !== 1'b1 || ctr1 !== 32'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_c0: acc_clr1=%b ctr1=%0d busy=%b, expected 1 0 1", acc_clr1, ctr1, busy);
        end
        run_to_done(2000);
        tests++;
        if (done_c - base != 821) begin
            fails++;
            $display("FAIL b2b_second_done: c%0d, expected c821", done_c - base);
        end
        tests++;
        if (q1.size() != 0 || q2.size() != 0) begin
            fails++;
            $display("FAIL b2b_missing: %0d l1 and %0d l2 beats never arrived", q1.size(), q2.size());
        end
        repeat (2) step();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_hold();
        test_start_during_run();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
